ws281x_pixel_rx: RTL and testbench

Parametrised WS281X receiver/splitter node: measures each high pulse on the incoming pixel stream, decodes bits, captures the first `NUM_NODE` pixels of every frame for local use, and forwards every subsequent pixel downstream. It sits directly behind the strip input pin and is the configurable successor to the fixed 24-bit, 8-branch splitter. It supports RGB or RGBW widths, any clock rate, glitch rejection, malformed-bit detection, and frame-latch reporting.

---
 rtl/ws281x_pkg.sv | 28 ++
 rtl/ws281x_din_sync.sv | 31 +++
 rtl/ws281x_pixel_rx.sv | 164 ++++++++++++++++
 tb/tb_ws281x_pixel_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ws281x_pkg.sv
// Shared WS281X definitions: receiver states, 50 MHz default timing and
// a time-to-clock helper used by both the receive and transmit blocks.
package ws281x_pkg;

    typedef logic [1:0] state_t;

    localparam state_t WAIT_LATCH = 2'd0;
    localparam state_t READY      = 2'd1;
    localparam state_t HIGH       = 2'd2;
    localparam state_t LOW        = 2'd3;

    localparam int CLK_MHZ = 50;

    // Rounds up so a threshold is never shorter than the requested time.
    function automatic int ns_to_clks(input int ns, input int clk_mhz);
        return (ns * clk_mhz + 999) / 1000;
    endfunction

    function automatic int us_to_clks(input int us, input int clk_mhz);
        return us * clk_mhz;
    endfunction

    localparam int DEF_GLITCH_CLKS   = ns_to_clks(100, CLK_MHZ);
    localparam int DEF_THRESH_CLKS   = ns_to_clks(440, CLK_MHZ);
    localparam int DEF_HIGH_MAX_CLKS = ns_to_clks(1200, CLK_MHZ);
    localparam int DEF_LATCH_CLKS    = us_to_clks(50, CLK_MHZ);

endpackage

// File: rtl/ws281x_din_sync.sv
// Two-flop synchronizer for the raw strip input with registered rise/fall
// pulses; lvl_rise is the same rise one cycle early for gating datapaths.
module ws281x_din_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic lvl_rise,
    output logic rise,
    output logic fall
);

    // [0] may go metastable, [1] is the clean level, [2] its one-cycle history
    logic [2:0] sync_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], din};
            rise      <= sync_pipe[1] & ~sync_pipe[2];
            fall      <= ~sync_pipe[1] & sync_pipe[2];
        end
    end

    assign lvl      = sync_pipe[1];
    assign lvl_rise = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/ws281x_pixel_rx.sv
// WS281X receiver node: decodes pulse widths into bits, keeps the first
// NUM_NODE pixels of each frame and forwards the rest of the stream.
module ws281x_pixel_rx
    import ws281x_pkg::*;
#(
    parameter int BITS_PER_PIXEL = 24,
    parameter int NUM_NODE       = 1,
    parameter int GLITCH_CLKS    = DEF_GLITCH_CLKS,
    parameter int THRESH_CLKS    = DEF_THRESH_CLKS,
    parameter int HIGH_MAX_CLKS  = DEF_HIGH_MAX_CLKS,
    parameter int LATCH_CLKS     = DEF_LATCH_CLKS
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Din,
    output logic                          Dout,
    output logic [BITS_PER_PIXEL-1:0]     Node,
    output logic [$clog2(NUM_NODE+1)-1:0] NodeIndex,
    output logic                          Valid,
    output logic                          Sync,
    output logic                          Error
);

    localparam int LW = $clog2(LATCH_CLKS + 1);
    // One spare count so an overlong high is always representable
    localparam int HW = $clog2(HIGH_MAX_CLKS + 2);
    localparam int BW = $clog2(BITS_PER_PIXEL + 1);
    localparam int PW = $clog2(NUM_NODE + 1);

    localparam logic [LW-1:0] LOW_FULL  = LW'(LATCH_CLKS);
    localparam logic [LW-1:0] LOW_LAST  = LW'(LATCH_CLKS - 1);
    localparam logic [HW-1:0] HIGH_OVER = HW'(HIGH_MAX_CLKS + 1);
    localparam logic [HW-1:0] HIGH_MAX  = HW'(HIGH_MAX_CLKS);
    localparam logic [HW-1:0] HIGH_GLT  = HW'(GLITCH_CLKS);
    localparam logic [HW-1:0] HIGH_ONE  = HW'(THRESH_CLKS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_PIXEL - 1);
    localparam logic [PW-1:0] PIX_FULL  = PW'(NUM_NODE);

    logic                      lvl, lvl_rise, rise, fall;
    state_t                    state;
    logic [LW-1:0]             low_cnt, low_inc;
    logic [HW-1:0]             high_cnt, high_inc;
    logic [BW-1:0]             bit_cnt;
    logic [PW-1:0]             pix_cnt, pix_inc;
    logic [BITS_PER_PIXEL-1:0] shreg, shreg_nxt;
    logic                      bit_val, fwd_arm, fwd_on;

    ws281x_din_sync u_sync (
        .clk      (Clock),
        .rst_n    (Reset),
        .din      (Din),
        .lvl      (lvl),
        .lvl_rise (lvl_rise),
        .rise     (rise),
        .fall     (fall)
    );

    assign bit_val   = (high_cnt >= HIGH_ONE);
    assign shreg_nxt = {shreg[BITS_PER_PIXEL-2:0], bit_val};
    assign low_inc   = (low_cnt == LOW_FULL) ? low_cnt : low_cnt + LW'(1);
    assign high_inc  = (high_cnt == HIGH_OVER) ? high_cnt : high_cnt + HW'(1);
    assign pix_inc   = (pix_cnt == PIX_FULL) ? pix_cnt : pix_cnt + PW'(1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= WAIT_LATCH;
            low_cnt   <= '0;
            high_cnt  <= '0;
            bit_cnt   <= '0;
            pix_cnt   <= '0;
            shreg     <= '0;
            fwd_arm   <= 1'b0;
            fwd_on    <= 1'b0;
            Dout      <= 1'b0;
            Node      <= '0;
            NodeIndex <= '0;
            Valid     <= 1'b0;
            Sync      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            Valid <= 1'b0;
            Sync  <= 1'b0;
            Error <= 1'b0;

            // Forwarding only opens on a fresh rise, so no partial pulse leaks out
            if (fwd_on || (fwd_arm && lvl_rise)) begin
                Dout   <= lvl;
                fwd_on <= 1'b1;
            end else begin
                Dout   <= 1'b0;
            end

            case (state)
                WAIT_LATCH: begin
                    if (lvl) begin
                        low_cnt <= '0;
                    end else if (low_cnt == LOW_LAST) begin
                        low_cnt <= LOW_FULL;
                        state   <= READY;
                    end else begin
                        low_cnt <= low_inc;
                    end
                end

                READY, LOW: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HW'(1);
                    end else if (state == LOW && low_cnt == LOW_LAST) begin
                        Sync    <= 1'b1;
                        Error   <= (bit_cnt != '0);
                        low_cnt <= LOW_FULL;
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                        fwd_arm <= 1'b0;
                        fwd_on  <= 1'b0;
                        Dout    <= 1'b0;
                        state   <= READY;
                    end else begin
                        low_cnt <= low_inc;
                    end
                end

                HIGH: begin
                    if (high_cnt > HIGH_MAX) begin
                        Error   <= 1'b1;
                        low_cnt <= '0;
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                        fwd_arm <= 1'b0;
                        fwd_on  <= 1'b0;
                        Dout    <= 1'b0;
                        state   <= WAIT_LATCH;
                    end else if (fall) begin
                        state <= LOW;
                        // Runt pulses leave the low-time measurement running
                        if (high_cnt >= HIGH_GLT) begin
                            shreg   <= shreg_nxt;
                            low_cnt <= LW'(1);
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                pix_cnt <= pix_inc;
                                if (pix_cnt < PIX_FULL) begin
                                    Node      <= shreg_nxt;
                                    NodeIndex <= pix_cnt;
                                    Valid     <= 1'b1;
                                end
                                if (pix_inc == PIX_FULL)
                                    fwd_arm <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end else begin
                        high_cnt <= high_inc;
                    end
                end

                default: state <= WAIT_LATCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ws281x_pixel_rx.sv
// Directed bench: a 24-bit two-pixel node and a 32-bit single-pixel node
// driven with hand-built WS281X waveforms at 50 MHz.
module tb_ws281x_pixel_rx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din_a = 1'b0;
    logic din_b = 1'b0;
    bit   sel_b = 1'b0;
    bit   fwd   = 1'b0;

    always #10 clk = ~clk;

    logic        dout_a, valid_a, sync_a, error_a;
    logic [23:0] node_a;
    logic [1:0]  idx_a;
    logic        dout_b, valid_b, sync_b, error_b;
    logic [31:0] node_b;
    logic [0:0]  idx_b;

    ws281x_pixel_rx #(.BITS_PER_PIXEL(24), .NUM_NODE(2)) dut_a (
        .Clock(clk), .Reset(rst_n), .Din(din_a), .Dout(dout_a), .Node(node_a),
        .NodeIndex(idx_a), .Valid(valid_a), .Sync(sync_a), .Error(error_a)
    );

    ws281x_pixel_rx #(.BITS_PER_PIXEL(32), .NUM_NODE(1)) dut_b (
        .Clock(clk), .Reset(rst_n), .Din(din_b), .Dout(dout_b), .Node(node_b),
        .NodeIndex(idx_b), .Valid(valid_b), .Sync(sync_b), .Error(error_b)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0, last_fall = 0;
    int va_cnt = 0, sa_cnt = 0, ea_cnt = 0, coin = 0, vs_coin = 0, sync_del = 0;
    int vb_cnt = 0, sb_cnt = 0, eb_cnt = 0, doutb_hi = 0;
    int dout_bad = 0, dout_hi = 0;
    logic [23:0] node_log [8];
    logic [1:0]  idx_log  [8];
    int          vdel_log [8];
    logic [31:0] nodeb_last = '0;
    logic [0:0]  idxb_last  = '0;
    logic [2:0]  fd = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        fd  <= {fd[1:0], din_a & fwd};
    end

    always @(negedge clk) begin
        if (valid_a) begin
            if (va_cnt < 8) begin
                node_log[va_cnt] <= node_a;
                idx_log[va_cnt]  <= idx_a;
                vdel_log[va_cnt] <= cyc - last_fall;
            end
            va_cnt <= va_cnt + 1;
        end
        if (sync_a) begin
            sa_cnt   <= sa_cnt + 1;
            sync_del <= cyc - last_fall;
        end
        if (error_a)            ea_cnt  <= ea_cnt + 1;
        if (sync_a && error_a)  coin    <= coin + 1;
        if (sync_a && valid_a)  vs_coin <= vs_coin + 1;
        if (dout_a !== fd[2])   dout_bad <= dout_bad + 1;
        if (dout_a)             dout_hi <= dout_hi + 1;
        if (valid_b) begin
            vb_cnt     <= vb_cnt + 1;
            nodeb_last <= node_b;
            idxb_last  <= idx_b;
        end
        if (sync_b)  sb_cnt   <= sb_cnt + 1;
        if (error_b) eb_cnt   <= eb_cnt + 1;
        if (dout_b)  doutb_hi <= doutb_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 && !v && (sel_b ? din_b : din_a))
                last_fall = cyc;
            if (sel_b) din_b = v;
            else       din_a = v;
        end
    endtask

    // g marks a 0-bit whose low time carries a 3-clock runt pulse
    task automatic send_bit(input logic b, input bit g);
        tick(1'b1, b ? 31 : 12);
        if (g) begin
            tick(1'b0, 20);
            tick(1'b1, 3);
            tick(1'b0, 27);
        end else begin
            tick(1'b0, b ? 31 : 50);
        end
    endtask

    task automatic send_pix(input logic [31:0] v, input int n, input int gi = -1);
        for (int i = n - 1; i >= 0; i--)
            send_bit(v[i], (i == gi) && !v[i]);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_dout",  32'(dout_a),  0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_sync",  32'(sync_a),  0);
        chk("rst_error", 32'(error_a), 0);
        chk("rst_node",  32'(node_a),  0);
        chk("rst_idx",   32'(idx_a),   0);
        rst_n = 1'b1;
        tick(1'b0, 3000);

        // Two captured pixels, the third forwarded
        send_pix(32'hAA0000, 24);
        send_pix(32'h00BB00, 24);
        fwd = 1'b1;
        send_pix(32'h0000CC, 24);
        fwd = 1'b0;
        tick(1'b0, 3000);
        chk("main_vcnt",  32'(va_cnt), 2);
        chk("main_node0", 32'(node_log[0]), 32'hAA0000);
        chk("main_idx0",  32'(idx_log[0]), 0);
        chk("main_node1", 32'(node_log[1]), 32'h00BB00);
        chk("main_idx1",  32'(idx_log[1]), 1);
        chk("valid_lat",  32'(vdel_log[0]), 4);
        chk("main_sync",  32'(sa_cnt), 1);
        chk("sync_lat",   32'(sync_del), 2503);
        chk("main_err",   32'(ea_cnt), 0);
        chk("dout_hi",    32'(dout_hi), 364);

        // Reset mid-frame, then pixels without a preceding latch gap
        send_pix(32'hF0, 8);
        tick(1'b1, 10);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_node",  32'(node_a),  0);
        chk("mid_idx",   32'(idx_a),   0);
        chk("mid_dout",  32'(dout_a),  0);
        chk("mid_valid", 32'(valid_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 5);
        tick(1'b0, 40);
        send_pix(32'hAA0000, 24);
        send_pix(32'h00BB00, 24);
        chk("prelatch_vcnt", 32'(va_cnt), 2);
        chk("prelatch_err",  32'(ea_cnt), 0);
        tick(1'b0, 3000);
        chk("wait_nosync",   32'(sa_cnt), 1);

        // Runt pulse inside the low time of the first 0-bit
        send_pix(32'h5A3C01, 24, 23);
        tick(1'b0, 3000);
        chk("glitch_vcnt", 32'(va_cnt), 3);
        chk("glitch_node", 32'(node_log[2]), 32'h5A3C01);
        chk("glitch_idx",  32'(idx_log[2]), 0);
        chk("glitch_err",  32'(ea_cnt), 0);
        chk("glitch_sync", 32'(sa_cnt), 2);

        // Overlong high aborts the frame until a fresh latch gap
        send_pix(32'h15, 5);
        tick(1'b1, 80);
        tick(1'b0, 40);
        send_pix(32'hAA0000, 24);
        chk("long_err",   32'(ea_cnt), 1);
        chk("long_vcnt",  32'(va_cnt), 3);
        tick(1'b0, 3000);
        chk("long_nosync", 32'(sa_cnt), 2);
        send_pix(32'h00FF00, 24);
        tick(1'b0, 3000);
        chk("rec_vcnt", 32'(va_cnt), 4);
        chk("rec_node", 32'(node_log[3]), 32'h00FF00);
        chk("rec_idx",  32'(idx_log[3]), 0);
        chk("rec_sync", 32'(sa_cnt), 3);

        // Truncated frame: partial pixel at latch
        send_pix(32'h123, 10);
        tick(1'b0, 3000);
        chk("trunc_sync", 32'(sa_cnt), 4);
        chk("trunc_err",  32'(ea_cnt), 2);
        chk("trunc_coin", 32'(coin), 1);
        chk("trunc_vcnt", 32'(va_cnt), 4);
        send_pix(32'h123ABC, 24);
        tick(1'b0, 3000);
        chk("after_vcnt", 32'(va_cnt), 5);
        chk("after_node", 32'(node_log[4]), 32'h123ABC);
        chk("after_idx",  32'(idx_log[4]), 0);
        chk("after_err",  32'(ea_cnt), 2);

        // 32-bit GRBW node
        sel_b = 1'b1;
        send_pix(32'h12345678, 32);
        tick(1'b0, 3000);
        sel_b = 1'b0;
        chk("w_vcnt", 32'(vb_cnt), 1);
        chk("w_node", nodeb_last, 32'h12345678);
        chk("w_idx",  32'(idxb_last), 0);
        chk("w_sync", 32'(sb_cnt), 1);
        chk("w_err",  32'(eb_cnt), 0);
        chk("w_dout", 32'(doutb_hi), 0);

        chk("dout_track", 32'(dout_bad), 0);
        chk("vs_coin",    32'(vs_coin), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
